fp_divider: RTL

// - Sequential IEEE-754 single-precision divider: fp_result = a / b.
// - Inverse-operation companion to the combinational FP32 multiplier.
// - Reports underflow/overflow/NaN in the same U/O/N style, plus divide-by-zero Z.
// - Iterative restoring mantissa division, one quotient bit per cycle.
// - Valid/ready handshake on both sides; sits in the FP datapath next to the multiplier.

---
 rtl/fp_divider.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider, fp_result = a / b, with U/O/N/Z flags.
// Latency: out_valid in the QBITS+3rd cycle counting the cycle after the accept edge (29 by default);
//          special operands are resolved in the 2nd cycle.
// Backpressure: one operation in flight; in_ready only in IDLE, the result is held in DONE until out_ready.
//
// Ports: clk, rst_n (async, active-low); in_valid/in_ready + a, b (FP32 operands);
//        out_valid/out_ready + fp_result (FP32 quotient), U underflow, O overflow, N NaN, Z divide-by-zero.
module fp_divider #(
    parameter int QBITS        = 26,   // 24 mantissa bits + guard + round; layout below assumes >= 26
    parameter bit FLUSH_DENORM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_result,
    output logic        U,
    output logic        O,
    output logic        N,
    output logic        Z
);

    localparam int CW = $clog2(QBITS);

    typedef enum logic [2:0] {IDLE, NORM, DIV, RND, DONE} state_t;

    state_t               state, state_nxt;
    logic [31:0]          a_q, b_q;
    logic                 sign_q;
    logic signed [9:0]    e_q;
    logic [23:0]          mb_q;
    logic [24:0]          rem_q;
    logic [QBITS-1:0]     q_q;
    logic [CW-1:0]        cnt_q;

    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (m[i]) n = 5'(23 - i);
        return n;
    endfunction

    // ---------------- unpack (used in NORM) ----------------
    logic [7:0]        ea_f, eb_f;
    logic [23:0]       ma_raw, mb_raw, ma_n, mb_n;
    logic [4:0]        lza, lzb;
    logic signed [9:0] ea_s, eb_s, e_base;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sgn, lt;

    assign ea_f   = a_q[30:23];
    assign eb_f   = b_q[30:23];
    assign ma_raw = {|ea_f, a_q[22:0]};
    assign mb_raw = {|eb_f, b_q[22:0]};
    assign lza    = lzc24(ma_raw);
    assign lzb    = lzc24(mb_raw);
    // Denormals are treated as exponent 1 and left-normalised so the divider always sees 1.xxx.
    assign ma_n   = ma_raw << lza;
    assign mb_n   = mb_raw << lzb;
    assign ea_s   = (ea_f == 8'd0) ? 10'sd1 - $signed({5'd0, lza}) : $signed({2'b00, ea_f});
    assign eb_s   = (eb_f == 8'd0) ? 10'sd1 - $signed({5'd0, lzb}) : $signed({2'b00, eb_f});
    assign e_base = ea_s - eb_s + 10'sd127;
    assign lt     = ma_n < mb_n;

    assign nan_a  = (ea_f == 8'hFF) && (a_q[22:0] != 23'd0);
    assign nan_b  = (eb_f == 8'hFF) && (b_q[22:0] != 23'd0);
    assign inf_a  = (ea_f == 8'hFF) && (a_q[22:0] == 23'd0);
    assign inf_b  = (eb_f == 8'hFF) && (b_q[22:0] == 23'd0);
    assign zero_a = (a_q[30:0] == 31'd0);
    assign zero_b = (b_q[30:0] == 31'd0);
    assign sgn    = a_q[31] ^ b_q[31];

    logic        special, spec_n, spec_z;
    logic [31:0] spec_res;

    always_comb begin
        special  = 1'b1;
        spec_res = 32'd0;
        spec_n   = 1'b0;
        spec_z   = 1'b0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_res = 32'h7FC00000;
            spec_n   = 1'b1;
        end else if (inf_a) begin
            spec_res = {sgn, 8'hFF, 23'd0};
        end else if (zero_b) begin
            spec_res = {sgn, 8'hFF, 23'd0};
            spec_z   = 1'b1;
        end else if (zero_a || inf_b) begin
            spec_res = {sgn, 31'd0};
        end else begin
            special  = 1'b0;
        end
    end

    // ---------------- one restoring-division step ----------------
    logic        rem_ge;
    logic [24:0] rem_diff, rem_nxt;

    assign rem_ge   = rem_q >= {1'b0, mb_q};
    assign rem_diff = rem_ge ? rem_q - {1'b0, mb_q} : rem_q;
    assign rem_nxt  = rem_diff << 1;   // rem_diff < mb, so the shift never loses a bit

    // ---------------- rounding (used in RND) ----------------
    logic              tiny, lost, g, rs, rup;
    logic [9:0]        den_diff, den_sh, e_fld;
    logic [QBITS-1:0]  q_rnd;
    logic [23:0]       mant;
    logic [32:0]       sum;
    logic signed [9:0] e_post;

    assign tiny     = e_q <= 10'sd0;
    assign den_diff = 10'sd1 - e_q;
    assign den_sh   = (den_diff > 10'(QBITS)) ? 10'(QBITS) : den_diff;
    assign q_rnd    = tiny ? (q_q >> den_sh) : q_q;
    // Bits shifted out by the denormal shift are the low den_sh bits of q.
    assign lost     = tiny && (|(q_q << (10'(QBITS) - den_sh)));
    assign mant     = q_rnd[QBITS-1 -: 24];
    assign g        = q_rnd[QBITS-25];
    assign rs       = |q_rnd[QBITS-26:0];
    assign rup      = g && (rs || lost || (|rem_q) || mant[0]);
    // Exponent field is stored as e-1 and the hidden bit carries into it, so a normal
    // result gets e back, a denormal gets 0, and any rounding carry bumps the exponent.
    assign e_fld    = tiny ? 10'd0 : e_q - 10'sd1;
    assign sum      = {e_fld, 23'd0} + {9'd0, mant} + {32'd0, rup};
    assign e_post   = $signed(sum[32:23]);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = NORM;
            NORM: state_nxt = special ? DONE : DIV;
            DIV:  if (cnt_q == CW'(QBITS - 1)) state_nxt = RND;
            RND:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0; b_q <= '0; sign_q <= 1'b0; e_q <= '0; mb_q <= '0;
            rem_q <= '0; q_q <= '0; cnt_q <= '0;
            fp_result <= '0; U <= 1'b0; O <= 1'b0; N <= 1'b0; Z <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= a; b_q <= b;
                    U <= 1'b0; O <= 1'b0; N <= 1'b0; Z <= 1'b0;
                end
                NORM: if (special) begin
                    fp_result <= spec_res;
                    N <= spec_n;
                    Z <= spec_z;
                end else begin
                    sign_q <= sgn;
                    mb_q   <= mb_n;
                    // Pre-scale a smaller dividend so the quotient lands in [1,2).
                    rem_q  <= lt ? {ma_n, 1'b0} : {1'b0, ma_n};
                    e_q    <= lt ? e_base - 10'sd1 : e_base;
                    q_q    <= '0;
                    cnt_q  <= '0;
                end
                DIV: begin
                    q_q   <= {q_q[QBITS-2:0], rem_ge};
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + 1'b1;
                end
                RND: begin
                    if (tiny && FLUSH_DENORM) begin
                        fp_result <= {sign_q, 31'd0};
                        U <= 1'b1;
                    end else if (e_post >= 10'sd255) begin
                        fp_result <= {sign_q, 8'hFF, 23'd0};
                        O <= 1'b1;
                    end else begin
                        fp_result <= {sign_q, sum[30:0]};
                        U <= tiny && (sum[30:0] != 31'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
